// File: rtl/bidirect_deserializer_if.sv
// Port bundle for the bidirectional serial-in/parallel-out receiver.
// Framing and serial inputs come from the master; the assembled word and status come back from the slave.
interface bidirect_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             dir;
  logic             bit_en;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             busy;
  logic             overrun;
  logic [0:0]       fsm_state;

  // valid has no ready partner: it is a one-cycle pulse and q holds until the next completion,
  // so a consumer that misses the pulse can still read the last word from q.
  modport master (
    output start, dir, bit_en, sin,
    input  q, valid, busy, overrun, fsm_state
  );

  modport slave (
    input  start, dir, bit_en, sin,
    output q, valid, busy, overrun, fsm_state
  );
endinterface

// File: rtl/bidirect_deserializer.sv
// Rebuilds WIDTH-bit words from a serial stream shifted MSB-first or LSB-first,
// framed by start; a new start while a frame is open drops it and flags overrun.
module bidirect_deserializer #(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  bidirect_deserializer_if.slave bus
);
  localparam int          CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             dir_l;
  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic             overrun_r;

  // dir_l=0 shifts toward the MSB (first bit ends up on top); dir_l=1 shifts toward the LSB.
  always_comb begin
    sr_next = sr;
    if (dir_l) sr_next = {bus.sin, sr[WIDTH-1:1]};
    else       sr_next = {sr[WIDTH-2:0], bus.sin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      sr        <= '0;
      dir_l     <= 1'b0;
      q_r       <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dir_l <= bus.dir;
            sr    <= '0;
            count <= '0;
            state <= RECV;
          end
        end
        RECV: begin
          // start wins over a coincident data bit; that bit belongs to the dropped frame
          if (bus.start) begin
            overrun_r <= 1'b1;
            dir_l     <= bus.dir;
            sr        <= '0;
            count     <= '0;
          end else if (bus.bit_en) begin
            sr <= sr_next;
            if (count == LAST) begin
              q_r     <= sr_next;
              valid_r <= 1'b1;
              count   <= '0;
              state   <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q         = q_r;
  assign bus.valid     = valid_r;
  assign bus.overrun   = overrun_r;
  assign bus.busy      = (state == RECV);
  assign bus.fsm_state = state;
endmodule
